// File: rtl/calc_bcd_pkg.sv
// Shared types and elaboration helpers for the calculator BCD output path.
package calc_bcd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    typedef logic [3:0] bcd_digit_t;

    // Decimal digits needed to hold the largest magnitude of a width-bit operand.
    function automatic int unsigned min_digits(input int unsigned width, input bit is_signed);
        longint unsigned mag;
        longint unsigned lim;
        int unsigned     d;
        mag = is_signed ? (64'd1 << (width - 1)) : ((64'd1 << width) - 64'd1);
        d   = 1;
        lim = 64'd10;
        while (lim <= mag) begin
            d   = d + 1;
            lim = lim * 64'd10;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One shift-and-add-3 correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
    import calc_bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one operand bit per clock, with valid/ready on both sides.
module binary_to_bcd_seq
    import calc_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned SIGNED = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_neg
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned BW = 4 * DIGITS;

    if (WIDTH < 2) begin : g_width_check
        $error("binary_to_bcd_seq: WIDTH must be at least 2");
    end
    if (DIGITS < min_digits(WIDTH, SIGNED != 0)) begin : g_digits_check
        $error("binary_to_bcd_seq: DIGITS too small for WIDTH/SIGNED");
    end

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]  bcd_q, bcd_d;
    logic           neg_q, neg_d;
    logic [BW-1:0]  out_bcd_q, out_bcd_d;
    logic           out_neg_q, out_neg_d;

    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_shifted;
    logic             in_neg;
    logic [WIDTH-1:0] in_mag;
    logic             unused_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (bcd_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    // The adjusted MSB always shifts out as zero because DIGITS covers the full range.
    assign unused_msb  = bcd_adj[BW-1];
    assign bcd_shifted = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};

    // Negating the most negative value wraps to 2**(WIDTH-1), which is the correct magnitude.
    assign in_neg = (SIGNED != 0) && in_data[WIDTH-1];
    assign in_mag = in_neg ? (~in_data + WIDTH'(1)) : in_data;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        out_bcd_d = out_bcd_q;
        out_neg_d = out_neg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bin_d   = in_mag;
                    neg_d   = in_neg;
                    bcd_d   = '0;
                    count_d = CW'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d   = bcd_shifted;
                bin_d   = bin_q << 1;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d   = ST_DONE;
                    out_bcd_d = bcd_shifted;
                    out_neg_d = neg_q;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            bin_d     = bin_q;
            bcd_d     = bcd_q;
            neg_d     = neg_q;
            out_bcd_d = out_bcd_q;
            out_neg_d = out_neg_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            out_bcd_q <= '0;
            out_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            out_bcd_q <= out_bcd_d;
            out_neg_q <= out_neg_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_bcd   = out_bcd_q;
    assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: three configurations checked against a decimal-arithmetic model.
module tb_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        out_ready;
    logic [2:0]  in_valid_v;
    logic [15:0] in_data;

    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  neg;
    logic [11:0] bcd0;
    logic [11:0] bcd1;
    logic [19:0] bcd2;

    int          sel;
    logic        o_ready;
    logic        o_valid;
    logic        o_neg;
    logic [19:0] o_bcd;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [19:0] got_bcd;
    logic        got_neg;

    always #5 clk = ~clk;

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_dut_u8 (
        .clk       (clk),
        .reset_n   (rst_n),
        .clear     (clear),
        .in_valid  (in_valid_v[0]),
        .in_ready  (rdy[0]),
        .in_data   (in_data[7:0]),
        .out_valid (vld[0]),
        .out_ready (out_ready),
        .out_bcd   (bcd0),
        .out_neg   (neg[0])
    );

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_dut_s8 (
        .clk       (clk),
        .reset_n   (rst_n),
        .clear     (clear),
        .in_valid  (in_valid_v[1]),
        .in_ready  (rdy[1]),
        .in_data   (in_data[7:0]),
        .out_valid (vld[1]),
        .out_ready (out_ready),
        .out_bcd   (bcd1),
        .out_neg   (neg[1])
    );

    binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_dut_u16 (
        .clk       (clk),
        .reset_n   (rst_n),
        .clear     (clear),
        .in_valid  (in_valid_v[2]),
        .in_ready  (rdy[2]),
        .in_data   (in_data),
        .out_valid (vld[2]),
        .out_ready (out_ready),
        .out_bcd   (bcd2),
        .out_neg   (neg[2])
    );

    always_comb begin
        o_ready = rdy[0];
        o_valid = vld[0];
        o_neg   = neg[0];
        o_bcd   = {8'h00, bcd0};
        case (sel)
            1: begin
                o_ready = rdy[1];
                o_valid = vld[1];
                o_neg   = neg[1];
                o_bcd   = {8'h00, bcd1};
            end
            2: begin
                o_ready = rdy[2];
                o_valid = vld[2];
                o_neg   = neg[2];
                o_bcd   = bcd2;
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Expected result from plain decimal arithmetic on the operand value.
    function automatic void ref_model(input int s, input logic [15:0] d,
                                      output logic [19:0] ebcd, output logic eneg,
                                      output int w);
        int m;
        eneg = 1'b0;
        w    = 8;
        case (s)
            0: m = int'(d[7:0]);
            1: begin
                eneg = d[7];
                m    = d[7] ? 256 - int'(d[7:0]) : int'(d[7:0]);
            end
            default: begin
                m = int'(d);
                w = 16;
            end
        endcase
        ebcd = '0;
        for (int i = 0; i < 5; i++) begin
            ebcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    task automatic do_conv(input int s, input logic [15:0] d, input int hold);
        logic [19:0] ebcd;
        logic        eneg;
        int          w;
        int          cyc;
        ref_model(s, d, ebcd, eneg, w);
        sel = s;
        @(negedge clk);
        check_eq("in_ready_idle", 32'(o_ready), 32'd1);
        in_data       = d;
        in_valid_v[s] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v = '0;
        check_eq("in_ready_busy", 32'(o_ready), 32'd0);
        cyc = 0;
        while (!o_valid && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(w));
        check_eq("bcd", 32'(o_bcd), 32'(ebcd));
        check_eq("neg", 32'(o_neg), 32'(eneg));
        got_bcd = o_bcd;
        got_neg = o_neg;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid_v[s] = 1'b1;
            in_data       = ~d;
            @(posedge clk);
            #1;
            in_valid_v = '0;
            check_eq("hold_valid", 32'(o_valid), 32'd1);
            check_eq("hold_ready", 32'(o_ready), 32'd0);
            check_eq("hold_bcd", 32'(o_bcd), 32'(ebcd));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_hs_valid", 32'(o_valid), 32'd0);
        check_eq("post_hs_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        int saw_valid;
        rst_n      = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b0;
        in_valid_v = '0;
        in_data    = '0;
        sel        = 0;
        #12;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check_eq("rst_ready", 32'(o_ready), 32'd1);
            check_eq("rst_valid", 32'(o_valid), 32'd0);
            check_eq("rst_bcd", 32'(o_bcd), 32'd0);
            check_eq("rst_neg", 32'(o_neg), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_conv(0, 16'd255, 0);
        check_eq("u8_max_const", 32'(got_bcd), 32'h255);
        do_conv(0, 16'd0, 0);
        check_eq("u8_zero_const", 32'(got_bcd), 32'h000);
        do_conv(0, 16'd99, 0);
        check_eq("u8_99_const", 32'(got_bcd), 32'h099);
        do_conv(1, 16'h0080, 0);
        check_eq("s8_min_const", 32'({got_neg, got_bcd}), 32'h1_00128);
        do_conv(1, 16'h00ff, 0);
        check_eq("s8_m1_const", 32'({got_neg, got_bcd}), 32'h1_00001);
        do_conv(1, 16'h007f, 0);
        check_eq("s8_max_const", 32'({got_neg, got_bcd}), 32'h0_00127);
        do_conv(1, 16'h0000, 0);
        check_eq("s8_zero_neg", 32'(got_neg), 32'd0);
        do_conv(2, 16'hffff, 0);
        check_eq("u16_max_const", 32'(got_bcd), 32'h65535);
        do_conv(0, 16'd42, 5);
        check_eq("bp_const", 32'(got_bcd), 32'h042);

        // clear together with in_valid while idle must not start a conversion
        sel = 0;
        @(negedge clk);
        clear         = 1'b1;
        in_data       = 16'd5;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        clear      = 1'b0;
        in_valid_v = '0;
        check_eq("clear_blocks_accept", 32'(o_ready), 32'd1);

        // abort at the fourth shift
        @(negedge clk);
        in_data       = 16'd77;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check_eq("clear_ready", 32'(o_ready), 32'd1);
        check_eq("clear_valid", 32'(o_valid), 32'd0);
        saw_valid = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (o_valid) saw_valid++;
        end
        check_eq("clear_no_valid", 32'(saw_valid), 32'd0);
        do_conv(0, 16'd200, 0);
        check_eq("after_clear_const", 32'(got_bcd), 32'h200);

        // asynchronous reset mid-shift; out_bcd still holds 200 going in
        @(negedge clk);
        in_data       = 16'd123;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready", 32'(o_ready), 32'd1);
        check_eq("arst_valid", 32'(o_valid), 32'd0);
        check_eq("arst_bcd", 32'(o_bcd), 32'd0);
        check_eq("arst_neg", 32'(o_neg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(0, 16'd200, 0);
        check_eq("after_rst_const", 32'(got_bcd), 32'h200);

        for (int i = 0; i < 1000; i++) begin
            do_conv(2, 16'($urandom_range(0, 65535)), 0);
        end
        for (int i = 0; i < 100; i++) begin
            do_conv(0, 16'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
            do_conv(1, 16'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
